// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared widths, stall encoding, load-type codes and the EX->MEM
//            bus layout for the memory-access pipeline stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  localparam int STALL_BUS    = 6;
  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

  localparam logic [2:0] LT_W  = 3'b000;
  localparam logic [2:0] LT_B  = 3'b001;
  localparam logic [2:0] LT_BU = 3'b010;
  localparam logic [2:0] LT_H  = 3'b011;
  localparam logic [2:0] LT_HU = 3'b100;

  typedef struct packed {
    logic [2:0]  load_type;
    logic [31:0] ex_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  function automatic logic is_load(input ex_to_mem_t b);
    return b.data_ram_en && (b.data_ram_wen == 4'b0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================================
// Module   : mem_stage_if
// Purpose  : Bundles the stall vector, EX input bus, SRAM read data and the
//            two MEM output buses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [STALL_BUS-1:0]    stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

  modport master (
    output stall, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_id_bus
  );

  modport slave (
    input  stall, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_id_bus
  );

endinterface

`default_nettype wire

// File: rtl/mem_load_ext.sv
// ============================================================================
// Module   : mem_load_ext
// Purpose  : Little-endian byte/halfword extraction with sign or zero extend.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rdata[{offset, 3'b000} +: 8];
  // The low offset bit is ignored for halfwords.
  assign w_half = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rdata;
    case (load_type)
      LT_B:    load_data = {{24{w_byte[7]}}, w_byte};
      LT_BU:   load_data = {24'h0, w_byte};
      LT_H:    load_data = {{16{w_half[15]}}, w_half};
      LT_HU:   load_data = {16'h0, w_half};
      default: load_data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage: latches EX results, extracts load data from
//            the synchronous SRAM and drives the WB and ID-forwarding buses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mem_stage_if.slave      bus
);

  ex_to_mem_t  r_ex_to_mem;
  logic        r_hold_valid;
  logic [31:0] r_hold_data;

  logic        w_stall_ex;
  logic        w_stall_wb;
  logic [31:0] w_rdata_eff;
  logic [31:0] w_load_data;
  logic [31:0] w_rf_wdata;

  assign w_stall_ex = bus.stall[STALL_EX_MEM];
  assign w_stall_wb = bus.stall[STALL_MEM_WB];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_to_mem <= '0;
    end else if (w_stall_ex == STOP && w_stall_wb == NO_STOP) begin
      r_ex_to_mem <= '0;
    end else if (w_stall_ex == NO_STOP) begin
      r_ex_to_mem <= ex_to_mem_t'(bus.ex_to_mem_bus);
    end
  end

  // SRAM data is only valid in the first MEM cycle; freeze it for stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
    end else if (w_stall_wb == NO_STOP) begin
      r_hold_valid <= 1'b0;
    end else if (!r_hold_valid && is_load(r_ex_to_mem)) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= bus.data_sram_rdata;
    end
  end

  assign w_rdata_eff = r_hold_valid ? r_hold_data : bus.data_sram_rdata;

  mem_load_ext u_load_ext (
    .rdata     (w_rdata_eff),
    .offset    (r_ex_to_mem.ex_result[1:0]),
    .load_type (r_ex_to_mem.load_type),
    .load_data (w_load_data)
  );

  assign w_rf_wdata = r_ex_to_mem.sel_rf_res ? w_load_data : r_ex_to_mem.ex_result;

  assign bus.mem_to_wb_bus = {r_ex_to_mem.ex_pc, r_ex_to_mem.rf_we,
                              r_ex_to_mem.rf_waddr, w_rf_wdata};
  assign bus.mem_to_id_bus = {r_ex_to_mem.rf_we, r_ex_to_mem.rf_waddr, w_rf_wdata};

endmodule

`default_nettype wire
